// File: rtl/table_pkg.sv
// table_pkg: shared definitions for the table move scheduler.
//   state_e          - scheduler FSM states
//   *_DEF            - default values for MAX_POS, SETTLE_CYC and TIMEOUT_CYC
package table_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE_HOME,
      ST_WAIT_HOME,
      ST_ISSUE_MOVE,
      ST_WAIT_MOVE,
      ST_SETTLE,
      ST_FAULT
   } state_e;
   localparam logic [31:0] MAX_POS_DEF     = 32'h000F_FFFF;
   localparam logic [15:0] SETTLE_CYC_DEF  = 16'd5000;
   localparam logic [31:0] TIMEOUT_CYC_DEF = 32'd100_000_000;
endpackage

// File: rtl/table_rr_arb2.sv
// table_rr_arb2: two-way round-robin arbiter with a last-grant pointer.
//   clk, rst_n  - clock, synchronous active-low reset
//   req_i[1:0]  - request per requester
//   adv_i       - grant taken this cycle; pointer moves to the winner
//   gnt_o[1:0]  - one-hot grant (zero when no request)
//   gnt_id_o    - index of the granted requester
module table_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       adv_i,
   output logic [1:0] gnt_o,
   output logic       gnt_id_o
);
   logic last_q, last_d;
   // On a tie the requester that did not win last time goes first.
   always_comb begin
      gnt_id_o = (&req_i) ? ~last_q : req_i[1];
      gnt_o    = (|req_i) ? (gnt_id_o ? 2'b10 : 2'b01) : 2'b00;
      last_d   = adv_i ? gnt_id_o : last_q;
   end
   // Pointer starts at requester 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (!rst_n) last_q <= 1'b1;
      else        last_q <= last_d;
   end
endmodule

// File: rtl/table_move_sched.sv
// table_move_sched: arbitrates move requests from host and panel, homes the
// table when needed, commands the motion executor, dwells after each move and
// guards the executor with a completion timeout.
//   clk, rst_n              - clock, synchronous active-low reset
//   req_valid[1:0]          - move request (0 = host, 1 = panel)
//   req_dest0, req_dest1    - requested absolute position per requester
//   req_ready[1:0]          - one-cycle accept pulse per requester
//   abort                   - level; stop the current operation
//   clear_fault             - one-cycle fault clear
//   exe_start/home/dest     - executor command (home/dest valid with start)
//   exe_done, exe_stop      - executor completion pulse, halt pulse
//   cur_pos, homed, busy, fault, grant_id - status
// Build option: TABLE_SOFT_LIMIT_EN clamps accepted destinations to MAX_POS.
module table_move_sched
   import table_pkg::*;
#(
   parameter logic [31:0] MAX_POS     = MAX_POS_DEF,
   parameter logic [15:0] SETTLE_CYC  = SETTLE_CYC_DEF,
   parameter logic [31:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   input  logic [31:0] req_dest0,
   input  logic [31:0] req_dest1,
   output logic [1:0]  req_ready,
   input  logic        abort,
   input  logic        clear_fault,
   output logic        exe_start,
   output logic        exe_home,
   output logic [31:0] exe_dest,
   input  logic        exe_done,
   output logic        exe_stop,
   output logic [31:0] cur_pos,
   output logic        homed,
   output logic        busy,
   output logic        fault,
   output logic        grant_id
);
`ifdef TABLE_SOFT_LIMIT_EN
   localparam bit SOFT_LIM_EN = 1'b1;
`else
   localparam bit SOFT_LIM_EN = 1'b0;
`endif
   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d, pos_q, pos_d, dest_q, dest_d;
   logic        homed_q, homed_d, gid_q, gid_d, stop_q, stop_d;
   logic [1:0]  gnt;
   logic        gnt_id, grant, active;
   logic [31:0] raw_dest, new_dest;
   assign active   = state_q != ST_IDLE && state_q != ST_FAULT;
   assign grant    = rst_n && state_q == ST_IDLE && !abort && |req_valid;
   assign raw_dest = gnt_id ? req_dest1 : req_dest0;
   assign new_dest = (SOFT_LIM_EN && raw_dest > MAX_POS) ? MAX_POS : raw_dest;
   table_rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    (req_valid),
      .adv_i    (grant),
      .gnt_o    (gnt),
      .gnt_id_o (gnt_id)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pos_q   <= '0;
         dest_q  <= '0;
         homed_q <= 1'b0;
         gid_q   <= 1'b0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pos_q   <= pos_d;
         dest_q  <= dest_d;
         homed_q <= homed_d;
         gid_q   <= gid_d;
         stop_q  <= stop_d;
      end
   end
   // Abort outranks everything, including an exe_done in the same cycle.
   // A destination equal to the known position (homed) skips straight to SETTLE.
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      dest_d  = dest_q;
      homed_d = homed_q;
      gid_d   = gid_q;
      stop_d  = 1'b0;
      if (abort && active) begin
         state_d = ST_IDLE;
         homed_d = 1'b0;
         stop_d  = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: if (grant) begin
               dest_d  = new_dest;
               gid_d   = gnt_id;
               state_d = !homed_q ? ST_ISSUE_HOME :
                         (new_dest == pos_q) ? ST_SETTLE : ST_ISSUE_MOVE;
            end
            ST_ISSUE_HOME: state_d = ST_WAIT_HOME;
            ST_ISSUE_MOVE: state_d = ST_WAIT_MOVE;
            ST_WAIT_HOME, ST_WAIT_MOVE: begin
               if (exe_done) begin
                  pos_d   = (state_q == ST_WAIT_HOME) ? '0 : dest_q;
                  homed_d = 1'b1;
                  state_d = (state_q == ST_WAIT_HOME && dest_q != '0) ? ST_ISSUE_MOVE : ST_SETTLE;
               end else if (cnt_q + 32'd1 >= TIMEOUT_CYC) begin
                  state_d = ST_FAULT;
                  homed_d = 1'b0;
                  stop_d  = 1'b1;
               end
            end
            ST_SETTLE: if (cnt_q + 32'd1 >= {16'd0, SETTLE_CYC}) state_d = ST_IDLE;
            ST_FAULT:  if (clear_fault) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
      // One counter serves both the WAIT timeout and the SETTLE dwell.
      cnt_d = (state_d != state_q || !active) ? '0 : cnt_q + 32'd1;
   end
   always_comb begin
      req_ready = grant ? gnt : 2'b00;
      exe_start = state_q == ST_ISSUE_HOME || state_q == ST_ISSUE_MOVE;
      exe_home  = state_q == ST_ISSUE_HOME;
      exe_dest  = (state_q == ST_ISSUE_MOVE) ? dest_q : '0;
      exe_stop  = stop_q;
      cur_pos   = pos_q;
      homed     = homed_q;
      busy      = active;
      fault     = state_q == ST_FAULT;
      grant_id  = gid_q;
   end
endmodule

// File: tb/tb_table_move_sched.sv
// tb_table_move_sched: directed and randomized checks of table_move_sched
// against an operation-level reference model.
module tb_table_move_sched;
   localparam logic [31:0] MAXP = 32'd5000;
   localparam int SET = 5;
   localparam int TMO = 100;
   localparam int M_IDLE = 0, M_CMD = 1, M_WAIT = 2, M_SETTLE = 3, M_FAULT = 4;
`ifdef TABLE_SOFT_LIMIT_EN
   localparam logic [31:0] EXP9000 = 32'd5000;
`else
   localparam logic [31:0] EXP9000 = 32'd9000;
`endif
   logic clk, rst_n, abort, clear_fault, exe_done;
   logic [1:0] req_valid, req_ready;
   logic [31:0] req_dest0, req_dest1, exe_dest, cur_pos;
   logic exe_start, exe_home, exe_stop, homed, busy, fault, grant_id;
   int checks = 0, errors = 0;
   int bfm_lat;
   bit spur;

   table_move_sched #(.MAX_POS(MAXP), .SETTLE_CYC(16'(SET)), .TIMEOUT_CYC(32'(TMO))) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_dest0(req_dest0),
      .req_dest1(req_dest1), .req_ready(req_ready), .abort(abort),
      .clear_fault(clear_fault), .exe_start(exe_start), .exe_home(exe_home),
      .exe_dest(exe_dest), .exe_done(exe_done), .exe_stop(exe_stop),
      .cur_pos(cur_pos), .homed(homed), .busy(busy), .fault(fault), .grant_id(grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: an operation is idle, a pending command, a wait on the
   // executor, a dwell, or a fault.
   int ph, m_left, m_el;
   bit m_home, m_homed, m_last, m_gid, m_stop, m_valid;
   logic [31:0] m_pos, m_dest;

   function automatic logic [31:0] lim(input logic [31:0] d);
`ifdef TABLE_SOFT_LIMIT_EN
      return (d > MAXP) ? MAXP : d;
`else
      return d;
`endif
   endfunction

   function automatic bit winner(input logic [1:0] r);
      return (r == 2'b11) ? !m_last : r[1];
   endfunction

   task goto_move;
      if (m_dest == m_pos) begin ph = M_SETTLE; m_left = SET; end
      else begin ph = M_CMD; m_home = 0; end
   endtask

   initial m_valid = 0;
   always @(posedge clk) begin
      if (!rst_n) begin
         ph = M_IDLE; m_pos = 0; m_dest = 0; m_homed = 0; m_last = 1; m_gid = 0;
         m_stop = 0; m_valid = 1;
      end else begin
         m_stop = 0;
         if (abort && (ph == M_CMD || ph == M_WAIT || ph == M_SETTLE)) begin
            m_stop = 1; m_homed = 0; ph = M_IDLE;
         end else if (ph == M_IDLE) begin
            if (!abort && req_valid != 0) begin
               m_gid = winner(req_valid);
               m_last = m_gid;
               m_dest = lim(m_gid ? req_dest1 : req_dest0);
               if (!m_homed) begin ph = M_CMD; m_home = 1; end
               else goto_move();
            end
         end else if (ph == M_CMD) begin
            ph = M_WAIT; m_el = 0;
         end else if (ph == M_WAIT) begin
            if (exe_done) begin
               if (m_home) begin m_pos = 0; m_homed = 1; goto_move(); end
               else begin m_pos = m_dest; ph = M_SETTLE; m_left = SET; end
            end else begin
               m_el++;
               if (m_el == TMO) begin ph = M_FAULT; m_stop = 1; m_homed = 0; end
            end
         end else if (ph == M_SETTLE) begin
            m_left--;
            if (m_left == 0) ph = M_IDLE;
         end else if (clear_fault) ph = M_IDLE;
      end
   end

   always @(negedge clk) begin
      logic [1:0] er;
      if (m_valid && rst_n) begin
         er = (ph == M_IDLE && !abort && req_valid != 0) ? (winner(req_valid) ? 2'b10 : 2'b01) : 2'b00;
         chk("cycle",
             {req_ready, exe_start, exe_home, exe_dest, exe_stop, cur_pos, homed, busy, fault, grant_id},
             {er, ph == M_CMD, ph == M_CMD && m_home, (ph == M_CMD && !m_home) ? m_dest : 32'd0,
              m_stop, m_pos, m_homed, ph == M_CMD || ph == M_WAIT || ph == M_SETTLE, ph == M_FAULT, m_gid});
      end
   end

   // Executor stand-in: answers exe_start with exe_done bfm_lat cycles later
   // (never when bfm_lat is 0), plus optional stray exe_done pulses.
   initial begin
      int left;
      left = 0;
      exe_done = 0;
      forever begin
         @(negedge clk);
         if (exe_start === 1'b1 && bfm_lat > 0) left = bfm_lat;
         @(posedge clk);
         #1;
         exe_done = 0;
         if (left > 0) begin
            left--;
            if (left == 0) exe_done = 1;
         end
         if (spur && $urandom_range(0, 19) == 0) exe_done = 1;
      end
   end

   task cyc;
      @(posedge clk);
      #1;
   endtask

   task wait_idle(input string nm);
      for (int n = 0; n < 500 && busy; n++) cyc();
      chk(nm, busy, 0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 4)
         0: return 32'd700;
         1: return 32'd9000;
         2: return 32'd100 * (1 + $urandom % 20);
         default: return (m_pos == 0) ? 32'd300 : m_pos;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int got;
      rst_n = 0; req_valid = 0; req_dest0 = 0; req_dest1 = 0; abort = 0; clear_fault = 0;
      bfm_lat = 1; spur = 0;
      repeat (3) cyc();
      rst_n = 1;
      @(negedge clk);
      chk("rst_status", {cur_pos, homed, busy, fault, grant_id}, 0);
      chk("rst_exe", {exe_start, exe_home, exe_dest, exe_stop, req_ready}, 0);
      // First move from reset: home, then move to 1000, then dwell.
      cyc(); req_valid = 2'b01; req_dest0 = 32'd1000;
      @(negedge clk); chk("t1_ready", req_ready, 2'b01);
      cyc(); req_valid = 0;
      @(negedge clk); chk("t1_home", {exe_start, exe_home, grant_id, busy}, 4'b1101);
      cyc(); cyc();
      @(negedge clk); chk("t1_move", {exe_start, exe_home, exe_dest, homed}, {1'b1, 1'b0, 32'd1000, 1'b1});
      cyc(); cyc();
      @(negedge clk); chk("t1_pos", {cur_pos, busy}, {32'd1000, 1'b1});
      repeat (4) cyc();
      @(negedge clk); chk("t1_settle_busy", busy, 1);
      cyc();
      @(negedge clk); chk("t1_settle_done", busy, 0);
      // Round robin: panel alone first, then both held -> 0, 1, 0.
      cyc(); req_valid = 2'b10; req_dest0 = 32'd200; req_dest1 = 32'd300;
      cyc(); req_valid = 0;
      wait_idle("t2_pre_idle");
      req_valid = 2'b11;
      got = 0;
      for (int n = 0; n < 300 && got < 3; n++) begin
         @(negedge clk);
         if (req_ready != 0) begin
            chk("t2_grant", req_ready, (got == 1) ? 2'b10 : 2'b01);
            got++;
            cyc();
            if (got == 3) req_valid = 0;
            @(negedge clk); chk("t2_pulse", req_ready, 0);
         end
         cyc();
      end
      chk("t2_count", got, 3);
      wait_idle("t2_idle");
      chk("t2_pos", cur_pos, 32'd200);
      // Same-position request skips the executor.
      req_valid = 2'b01; req_dest0 = 32'd700;
      cyc(); req_valid = 0;
      wait_idle("t3_pre_idle");
      chk("t3_pos", cur_pos, 32'd700);
      req_valid = 2'b01;
      @(negedge clk); chk("t3_ready", req_ready, 2'b01);
      cyc(); req_valid = 0;
      for (int i = 0; i < SET; i++) begin
         @(negedge clk); chk("t3_nostart", {exe_start, busy}, 2'b01);
         cyc();
      end
      @(negedge clk); chk("t3_idle", busy, 0);
      // Abort collides with exe_done in WAIT_MOVE.
      bfm_lat = 3;
      cyc(); req_valid = 2'b01; req_dest0 = 32'd1234;
      cyc(); req_valid = 0;
      cyc(); cyc(); cyc(); abort = 1;
      cyc(); abort = 0;
      @(negedge clk); chk("t4_stop", {exe_stop, busy, homed}, 3'b100);
      chk("t4_pos", cur_pos, 32'd700);
      cyc();
      @(negedge clk); chk("t4_stop_once", exe_stop, 0);
      bfm_lat = 1;
      cyc(); req_valid = 2'b01; req_dest0 = 32'd50;
      cyc(); req_valid = 0;
      @(negedge clk); chk("t4_rehome", {exe_start, exe_home}, 2'b11);
      wait_idle("t4_idle");
      chk("t4_pos2", cur_pos, 32'd50);
      // Destination beyond the soft limit.
      req_valid = 2'b01; req_dest0 = 32'd9000;
      cyc(); req_valid = 0;
      @(negedge clk); chk("t5_dest", {exe_start, exe_dest}, {1'b1, EXP9000});
      wait_idle("t5_idle");
      // Executor never answers -> timeout fault.
      bfm_lat = 0;
      req_valid = 2'b01; req_dest0 = 32'd100;
      cyc(); req_valid = 0;
      cyc();
      repeat (TMO - 1) cyc();
      @(negedge clk); chk("t6_before", {fault, exe_stop}, 2'b00);
      cyc();
      @(negedge clk); chk("t6_fault", {fault, exe_stop, homed, busy}, 4'b1100);
      cyc(); req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("t6_noreq", {req_ready, fault, exe_stop}, 4'b0010);
         cyc();
      end
      clear_fault = 1; req_valid = 0;
      cyc(); clear_fault = 0;
      @(negedge clk); chk("t6_clear", {fault, busy, homed}, 3'b000);
      // Randomized traffic against the model.
      spur = 1;
      for (int n = 0; n < 4000; n++) begin
         cyc();
         if (n % 500 == 0) bfm_lat = $urandom_range(0, 4);
         if ($urandom % 3 == 0) req_valid = 2'($urandom);
         if ($urandom % 4 == 0) req_dest0 = pick();
         if ($urandom % 4 == 0) req_dest1 = pick();
         abort = ($urandom % 60 == 0);
         clear_fault = ($urandom % 10 == 0);
         rst_n = !(n >= 2000 && n < 2002);
      end
      cyc();
      abort = 0; clear_fault = 0; req_valid = 0; spur = 0;
      repeat (5) cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/table_move_sched.md
TABLE_MOVE_SCHED -- requirements
Module: table_move_sched

Interface
REQ-001 SHALL have parameter MAX_POS, default 32'h000F_FFFF, upper travel limit in steps.
REQ-002 SHALL have parameter SETTLE_CYC, default 16'd5000, post-move dwell in clk cycles.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 32'd100_000_000, executor completion limit in clk cycles.
REQ-004 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous to clk, active-low.
REQ-006 SHALL have ports req_valid  input  2  move request, one bit per requester (0 = host, 1 = panel).
REQ-007 SHALL have ports req_dest0 and req_dest1  input  32  requested absolute position per requester.
REQ-008 SHALL have port req_ready  output  2  one-cycle accept pulse per requester.
REQ-009 SHALL have port abort  input  1  level; stop the current operation.
REQ-010 SHALL have port clear_fault  input  1  one-cycle fault clear.
REQ-011 SHALL have ports exe_start  output  1, exe_home  output  1, exe_dest  output  32  executor command; exe_home/exe_dest valid while exe_start high.
REQ-012 SHALL have ports exe_done  input  1  executor completion pulse; exe_stop  output  1  executor halt pulse.
REQ-013 SHALL have ports cur_pos  output  32, homed  output  1, busy  output  1, fault  output  1, grant_id  output  1.

Function
REQ-014 SHALL implement states IDLE, ISSUE_HOME, WAIT_HOME, ISSUE_MOVE, WAIT_MOVE, SETTLE, FAULT.
REQ-015 IDLE: with any req_valid set, SHALL grant round-robin (last-granted requester has lower priority; after reset, requester 0 wins a tie), pulse req_ready for the granted bit in the same cycle, latch its dest, and set grant_id.
REQ-016 From IDLE on a grant: if homed=0, SHALL go to ISSUE_HOME; otherwise SHALL go to ISSUE_MOVE.
REQ-017 ISSUE_HOME/ISSUE_MOVE: SHALL pulse exe_start for exactly one cycle, with exe_home=1 for a home and exe_dest=latched dest for a move, then enter the matching WAIT state.
REQ-018 WAIT_HOME on exe_done: SHALL set cur_pos=0, set homed=1, and go to ISSUE_MOVE.
REQ-019 WAIT_MOVE on exe_done: SHALL set cur_pos=latched dest and go to SETTLE.
REQ-020 If latched dest equals cur_pos with homed=1, SHALL skip ISSUE_MOVE, issue no exe_start, and go directly to SETTLE.
REQ-021 SETTLE: SHALL count SETTLE_CYC cycles, then return to IDLE; requests arriving during SETTLE are held until IDLE.
REQ-022 A 32-bit timeout counter SHALL run in WAIT_HOME/WAIT_MOVE; at count reaching TIMEOUT_CYC it SHALL pulse exe_stop, clear homed, set fault, and enter FAULT.
REQ-023 abort=1 in any non-IDLE, non-FAULT state SHALL pulse exe_stop once, clear homed, and return to IDLE without updating cur_pos; while abort=1, no grant SHALL occur.
REQ-024 exe_done arriving in the same cycle as abort SHALL be ignored; abort wins.
REQ-025 FAULT: SHALL accept no requests; clear_fault SHALL clear fault and go to IDLE.
REQ-026 exe_done received outside a WAIT state SHALL be ignored.
REQ-027 busy SHALL be 1 in every state except IDLE and FAULT.
REQ-028 Latency: in the normal case, grant to exe_start SHALL be 1 cycle.

Reset
REQ-029 When rst_n=0 at a clk edge, the block SHALL enter IDLE with req_ready=0, exe_start=0, exe_home=0, exe_dest=0, exe_stop=0, cur_pos=0, homed=0, busy=0, fault=0, grant_id=0, counters=0, and round-robin pointer favoring requester 0.
REQ-030 Reset mid-move SHALL not pulse exe_stop; the system integrator SHALL reset the executor together with this block.

Configuration
REQ-031 With TABLE_SOFT_LIMIT_EN defined, a dest > MAX_POS SHALL be clamped to MAX_POS at latch time; without it, dest SHALL pass unmodified.

Structure
REQ-032 State encodings and the default values of SETTLE_CYC, TIMEOUT_CYC and MAX_POS SHALL live in the shared package table_pkg.
REQ-033 The round-robin grant logic SHALL be the sub-module table_rr_arb2 (2-way arbiter with a last-grant pointer).

Verification
REQ-034 Reset, then req_valid=2'b01 with dest0=1000 -> exe_start with exe_home=1; exe_done -> exe_start with exe_dest=1000; exe_done -> cur_pos=1000; busy drops after SETTLE_CYC cycles.
REQ-035 req_valid=2'b11 held, dest0=200, dest1=300, homed=1 -> grants in order 0, 1, 0 across three moves; each req_ready is a single-cycle pulse.
REQ-036 TIMEOUT_CYC=100 with exe_done withheld -> exe_stop pulse and fault=1 at cycle 100; requests are ignored; clear_fault -> IDLE, homed=0.
REQ-037 abort in WAIT_MOVE with exe_done in the same cycle -> one exe_stop pulse, cur_pos unchanged, homed=0; the next request re-homes first.
REQ-038 With TABLE_SOFT_LIMIT_EN and MAX_POS=5000, dest0=9000 -> exe_dest=5000; without the macro -> exe_dest=9000.
REQ-039 With homed=1 and cur_pos=700, dest=700 -> no exe_start; go to SETTLE, then IDLE.
